ring_stop: RTL and testbench
============================

# ring_stop

Single stop of the unidirectional force-writeback ring, one instance per cell. It accepts force packets from the local PE over a valid/ready injection handshake and buffers them. Each cycle it either forwards the upstream ring packet or injects a buffered one. Packets addressed to this node are ejected as write requests to the local force cache. Ring traffic always has priority and never stalls; back-pressure is applied only to the local PE.

## Interface
- NUM_CELLS, 64, number of ring stops.
- DATA_WIDTH, 32, width of one force component.
- PARTICLE_ID_WIDTH, 7, width of the particle index within a cell.
- NODE_ID_WIDTH, $clog2(NUM_CELLS), width of the destination node field.
- NODE_ID, 0, this stop's node number, in the range 0..NUM_CELLS-1.
- INJ_DEPTH, 4, injection FIFO depth; must be a power of 2 and at least 2.
- STARVE_LIMIT, 64, consecutive blocked cycles before `starve` asserts.
- FORCE_DATA_WIDTH, 3*DATA_WIDTH+PARTICLE_ID_WIDTH, ejected payload width.
- PACKET_WIDTH, FORCE_DATA_WIDTH+NODE_ID_WIDTH, packet width; the destination field is in the MSBs.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- ring_in_valid, input, 1: upstream stop's registered output is valid.
- ring_in_pkt, input, PACKET_WIDTH: upstream packet.
- ring_out_valid, output, 1: registered packet to the downstream stop is valid.
- ring_out_pkt, output, PACKET_WIDTH: registered packet to the downstream stop.
- inj_valid, input, 1: PE presents a packet.
- inj_pkt, input, PACKET_WIDTH: PE packet.
- inj_ready, output, 1: FIFO can accept the packet this cycle.
- ej_valid, output, 1: registered write enable to the local force cache.
- ej_data, output, FORCE_DATA_WIDTH: `pkt[FORCE_DATA_WIDTH-1:0]` of the ejected packet.
- inj_empty, output, 1: injection FIFO is empty.
- starve, output, 1: injection has been blocked for STARVE_LIMIT or more cycles.

## Operation
- Destination of a packet is `pkt[PACKET_WIDTH-1 -: NODE_ID_WIDTH]`.
- The head of the FIFO is called H.
- Decision each cycle, in priority order:
  1. `ring_in_valid` and dest == NODE_ID: eject the upstream packet. The output slot is free, so inject H if the FIFO is non-empty and H.dest != NODE_ID.
  2. `ring_in_valid` and dest != NODE_ID: forward the packet to `ring_out`. No injection and no self-ejection this cycle.
  3. `ring_in_valid` low and FIFO non-empty: if H.dest == NODE_ID, eject H locally and do not use the ring. Otherwise inject H onto `ring_out`.
- In case 1, if H.dest == NODE_ID, H waits, because the ejection port is taken.
- A FIFO pop happens only when H is injected or self-ejected.
- Push rule: push when `inj_valid & inj_ready`.
  - `inj_ready` = `!full`; it is low during rst.
  - A pop does not free a slot for a push in the same cycle.
- FIFO pointers are `$clog2(INJ_DEPTH)+1` bits and wrap naturally. Full is when the low bits are equal and the MSBs differ.
- Starvation counter:
  - Increments when the FIFO is non-empty and nothing is popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - `starve` = (counter == STARVE_LIMIT).
- Packets are neither dropped nor reordered. Ejection order equals arrival order at this stop. Injection order equals PE order.

## Timing
- Reset values: `ring_out_valid`=0, `ring_out_pkt`=0, `ej_valid`=0, `ej_data`=0, `inj_ready`=0, `inj_empty`=1, `starve`=0. FIFO pointers are 0 and the starvation counter is 0.
- Reset mid-operation discards all buffered and in-flight packets. `inj_ready` rises the first cycle after rst deasserts.
- Forward latency: 1 cycle from `ring_in` to `ring_out`.
- Eject latency: 1 cycle from `ring_in` to `ej_*`.
- Minimum injection latency: a packet pushed in cycle t is visible as H in t+1. It appears on `ring_out` or `ej_*` in t+2 at the earliest.
- `ring_out_valid` and `ej_valid` are pulsed per packet and hold no state. `ring_out_pkt` holds its last value when valid is low.
- Both `ring_out_valid` and `ej_valid` can be high in the same cycle (case 1 with injection).
- `inj_empty` reflects the registered FIFO state. It is used with the top-level drain counter to detect that all writeback has left the PEs.

## Test plan
Parameters for all tests: NUM_CELLS=8, NODE_ID=5, INJ_DEPTH=4.

- **Forward:** `ring_in` carries dest=2, payload=0xABC for 1 cycle → `ring_out_valid`=1 with the identical packet 1 cycle later; `ej_valid` stays 0.
- **Eject with concurrent inject:** FIFO holds H with dest=3; `ring_in` carries dest=5 → the next cycle has `ej_valid`=1 with `ej_data` = the upstream payload, and `ring_out` = H. `inj_empty` goes to 1.
- **Self-delivery:** idle ring; push one packet with dest=5 → `ej_valid`=1 two cycles after the push cycle; `ring_out_valid` stays 0.
- **Full / back-pressure:** hold `inj_valid`=1 with 6 distinct packets while `ring_in_valid` is held at 1 with dest=1 → `inj_ready` drops after 4 accepts. After `ring_in_valid` falls, the 4 packets emerge in order, and pushes 5–6 complete afterward.
- **Starvation:** FIFO non-empty with continuous foreign traffic for 64 cycles → `starve`=1 from cycle 64. The first idle ring cycle injects, and `starve` clears the next cycle.
- **Reset mid-run:** 3 packets buffered and 1 on `ring_out`; assert rst for 1 cycle → all outputs at reset values, and no stale packet appears afterward.

Source files
------------

// File: rtl/ring_stop.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ring_stop : one stop of the force-writeback ring (forward / eject / inject)
// Revision  : 1.0
// ----------------------------------------------------------------------------
module ring_stop #(
  parameter int NUM_CELLS         = 64,
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
  parameter int NODE_ID           = 0,
  parameter int INJ_DEPTH         = 4,
  parameter int STARVE_LIMIT      = 64,
  parameter int FORCE_DATA_WIDTH  = 3*DATA_WIDTH+PARTICLE_ID_WIDTH,
  parameter int PACKET_WIDTH      = FORCE_DATA_WIDTH+NODE_ID_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ring_in_valid,
  input  logic [PACKET_WIDTH-1:0]     ring_in_pkt,
  output logic                        ring_out_valid,
  output logic [PACKET_WIDTH-1:0]     ring_out_pkt,
  input  logic                        inj_valid,
  input  logic [PACKET_WIDTH-1:0]     inj_pkt,
  output logic                        inj_ready,
  output logic                        ej_valid,
  output logic [FORCE_DATA_WIDTH-1:0] ej_data,
  output logic                        inj_empty,
  output logic                        starve
);

  localparam int ADDR_W = $clog2(INJ_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [NODE_ID_WIDTH-1:0] SELF_ID    = NODE_ID_WIDTH'(NODE_ID);
  localparam logic [CNT_W-1:0]         STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [PACKET_WIDTH-1:0] r_mem [INJ_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_starve_cnt;

  logic                    w_empty;
  logic                    w_full;
  logic [PACKET_WIDTH-1:0] w_head;
  logic                    w_head_self;
  logic                    w_in_self;
  logic                    w_forward;
  logic                    w_eject_in;
  logic                    w_inject;
  logic                    w_self_eject;
  logic                    w_pop;
  logic                    w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]);
  assign w_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

  assign w_head_self = (w_head[PACKET_WIDTH-1 -: NODE_ID_WIDTH] == SELF_ID);
  assign w_in_self   = (ring_in_pkt[PACKET_WIDTH-1 -: NODE_ID_WIDTH] == SELF_ID);

  // Ring traffic wins; the head only goes out when the output slot is free.
  assign w_forward    = ring_in_valid && !w_in_self;
  assign w_eject_in   = ring_in_valid && w_in_self;
  assign w_inject     = !w_empty && !w_head_self && !w_forward;
  assign w_self_eject = !w_empty && w_head_self && !ring_in_valid;
  assign w_pop        = w_inject || w_self_eject;

  // Readiness ignores a same-cycle pop so the accept path stays short.
  assign inj_ready = !rst && !w_full;
  assign w_push    = inj_valid && inj_ready;
  assign inj_empty = w_empty;
  assign starve    = (r_starve_cnt == STARVE_MAX);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= inj_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_pop || w_empty) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_out_valid <= 1'b0;
      ring_out_pkt   <= '0;
      ej_valid       <= 1'b0;
      ej_data        <= '0;
    end else begin
      ring_out_valid <= w_forward || w_inject;
      ej_valid       <= w_eject_in || w_self_eject;
      if (w_forward) begin
        ring_out_pkt <= ring_in_pkt;
      end else if (w_inject) begin
        ring_out_pkt <= w_head;
      end
      if (w_eject_in) begin
        ej_data <= ring_in_pkt[FORCE_DATA_WIDTH-1:0];
      end else if (w_self_eject) begin
        ej_data <= w_head[FORCE_DATA_WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_stop.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ring_stop : directed + randomized bench with a queue-based reference model
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_ring_stop;

  localparam int NUM_CELLS = 8;
  localparam int NODE_ID   = 5;
  localparam int INJ_DEPTH = 4;
  localparam int STARVE    = 64;
  localparam int NIW       = 3;
  localparam int FD        = 3*32+7;
  localparam int PW        = FD + NIW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ring_in_valid = 1'b0;
  logic [PW-1:0] ring_in_pkt = '0;
  logic          ring_out_valid;
  logic [PW-1:0] ring_out_pkt;
  logic          inj_valid = 1'b0;
  logic [PW-1:0] inj_pkt = '0;
  logic          inj_ready;
  logic          ej_valid;
  logic [FD-1:0] ej_data;
  logic          inj_empty;
  logic          starve;

  ring_stop #(
    .NUM_CELLS(NUM_CELLS), .NODE_ID(NODE_ID), .INJ_DEPTH(INJ_DEPTH), .STARVE_LIMIT(STARVE)
  ) dut (
    .clk(clk), .rst(rst),
    .ring_in_valid(ring_in_valid), .ring_in_pkt(ring_in_pkt),
    .ring_out_valid(ring_out_valid), .ring_out_pkt(ring_out_pkt),
    .inj_valid(inj_valid), .inj_pkt(inj_pkt), .inj_ready(inj_ready),
    .ej_valid(ej_valid), .ej_data(ej_data),
    .inj_empty(inj_empty), .starve(starve)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int dest, input logic [FD-1:0] pay);
    return {NIW'(dest), pay};
  endfunction

  function automatic int dst(input logic [PW-1:0] p);
    return int'(p[PW-1 -: NIW]);
  endfunction

  function automatic logic [FD-1:0] rnd_pay();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[FD-1:0];
  endfunction

  // Reference model: a queue plus the routing priority rules.
  logic [PW-1:0] q[$];
  bit            started = 0;
  logic          m_rov = 0;
  logic [PW-1:0] m_rop = '0;
  logic          m_ejv = 0;
  logic [FD-1:0] m_ejd = '0;
  int            m_cnt = 0;

  initial forever begin
    int pre_n;
    bit popped;
    logic [PW-1:0] h;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_rov = 0; m_rop = '0; m_ejv = 0; m_ejd = '0; m_cnt = 0;
      started = 1;
    end else begin
      pre_n = q.size();
      popped = 0;
      m_rov = 0;
      m_ejv = 0;
      if (ring_in_valid && dst(ring_in_pkt) == NODE_ID) begin
        m_ejv = 1;
        m_ejd = ring_in_pkt[FD-1:0];
        if (pre_n > 0 && dst(q[0]) != NODE_ID) begin
          m_rop = q.pop_front();
          m_rov = 1;
          popped = 1;
        end
      end else if (ring_in_valid) begin
        m_rov = 1;
        m_rop = ring_in_pkt;
      end else if (pre_n > 0) begin
        h = q.pop_front();
        popped = 1;
        if (dst(h) == NODE_ID) begin
          m_ejv = 1;
          m_ejd = h[FD-1:0];
        end else begin
          m_rov = 1;
          m_rop = h;
        end
      end
      if (inj_valid && pre_n < INJ_DEPTH) q.push_back(inj_pkt);
      if (popped || pre_n == 0) m_cnt = 0;
      else if (m_cnt < STARVE) m_cnt++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (started) begin
      chk("ring_out_valid", ring_out_valid, m_rov);
      chk("ring_out_pkt", ring_out_pkt, m_rop);
      chk("ej_valid", ej_valid, m_ejv);
      chk("ej_data", ej_data, m_ejd);
      chk("inj_ready", inj_ready, (!rst && q.size() < INJ_DEPTH));
      chk("inj_empty", inj_empty, (q.size() == 0));
      chk("starve", starve, (m_cnt == STARVE));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dests[6];
    logic [PW-1:0] pk[6];
    int k;
    bit acc;
    dests = '{0, 1, 2, 3, 4, 6};

    // reset values
    step(); step();
    chk("rst_ring_out_valid", ring_out_valid, 1'b0);
    chk("rst_ring_out_pkt", ring_out_pkt, '0);
    chk("rst_ej_valid", ej_valid, 1'b0);
    chk("rst_inj_ready", inj_ready, 1'b0);
    chk("rst_inj_empty", inj_empty, 1'b1);
    chk("rst_starve", starve, 1'b0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", inj_ready, 1'b1);

    // forward
    ring_in_valid = 1'b1;
    ring_in_pkt = mk(2, FD'('hABC));
    step();
    ring_in_valid = 1'b0;
    chk("fwd_valid", ring_out_valid, 1'b1);
    chk("fwd_pkt", ring_out_pkt, {3'd2, 103'hABC});
    chk("fwd_no_eject", ej_valid, 1'b0);

    // eject with concurrent inject
    ring_in_valid = 1'b1;
    ring_in_pkt = mk(1, FD'('h999));
    inj_valid = 1'b1;
    inj_pkt = mk(3, FD'('h111));
    step();
    inj_valid = 1'b0;
    ring_in_pkt = mk(5, FD'('h222));
    step();
    ring_in_valid = 1'b0;
    chk("ej_inj_ej_valid", ej_valid, 1'b1);
    chk("ej_inj_ej_data", ej_data, 103'h222);
    chk("ej_inj_out_valid", ring_out_valid, 1'b1);
    chk("ej_inj_out_pkt", ring_out_pkt, {3'd3, 103'h111});
    chk("ej_inj_empty", inj_empty, 1'b1);

    // self-delivery
    inj_valid = 1'b1;
    inj_pkt = mk(5, FD'('h333));
    step();
    inj_valid = 1'b0;
    chk("self_not_yet", ej_valid, 1'b0);
    step();
    chk("self_ej_valid", ej_valid, 1'b1);
    chk("self_ej_data", ej_data, 103'h333);
    chk("self_no_ring", ring_out_valid, 1'b0);

    // full / back-pressure under continuous foreign ring traffic
    for (int i = 0; i < 6; i++) pk[i] = mk(dests[i], FD'(32'h1000 + i));
    ring_in_valid = 1'b1;
    ring_in_pkt = mk(1, FD'('hF00));
    inj_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      inj_pkt = pk[k];
      acc = inj_ready;
      step();
      if (acc) k++;
    end
    chk("full_accepts", k, 4);
    chk("full_ready_low", inj_ready, 1'b0);
    ring_in_valid = 1'b0;
    inj_pkt = pk[k];
    acc = inj_ready;
    step();
    if (acc) k++;
    chk("full_first_out", ring_out_pkt, {3'd0, 103'h1000});
    for (int c = 0; c < 30 && k < 6; c++) begin
      inj_pkt = pk[k];
      acc = inj_ready;
      step();
      if (acc) k++;
    end
    inj_valid = 1'b0;
    chk("full_all_pushed", k, 6);
    repeat (12) step();

    // starvation
    ring_in_valid = 1'b1;
    ring_in_pkt = mk(7, FD'('hBEEF));
    inj_valid = 1'b1;
    inj_pkt = mk(2, FD'('h55));
    step();
    inj_valid = 1'b0;
    repeat (63) step();
    chk("starve_63", starve, 1'b0);
    step();
    chk("starve_64", starve, 1'b1);
    ring_in_valid = 1'b0;
    step();
    chk("starve_inject", ring_out_pkt, {3'd2, 103'h55});
    chk("starve_cleared", starve, 1'b0);
    repeat (3) step();

    // reset mid-run
    ring_in_valid = 1'b1;
    ring_in_pkt = mk(4, FD'('h77));
    inj_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inj_pkt = mk(0, FD'(32'h2000 + i));
      step();
    end
    inj_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_out_valid", ring_out_valid, 1'b0);
    chk("mid_rst_out_pkt", ring_out_pkt, '0);
    chk("mid_rst_ej_data", ej_data, '0);
    chk("mid_rst_empty", inj_empty, 1'b1);
    chk("mid_rst_ready", inj_ready, 1'b0);
    rst = 1'b0;
    ring_in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_rst_no_out", ring_out_valid, 1'b0);
      chk("post_rst_no_ej", ej_valid, 1'b0);
    end

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      ring_in_valid = ($urandom_range(0, 99) < 55);
      ring_in_pkt = mk($urandom_range(0, NUM_CELLS-1), rnd_pay());
      inj_valid = ($urandom_range(0, 99) < 50);
      inj_pkt = mk($urandom_range(0, NUM_CELLS-1), rnd_pay());
      step();
    end
    rst = 1'b0;
    ring_in_valid = 1'b0;
    inj_valid = 1'b0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
